// File: rtl/ahb_req_packer.sv
// AHB-Lite slave front end of the AHB-APB bridge (HCLK domain).
// Each accepted NONSEQ/SEQ transfer becomes one entry in the request FIFO.
// Writes are posted; reads stall until the response FIFO returns data.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no data phase pending; ready, OKAY
// WDATA | write data phase; push {ctrl, hwdata} once the request FIFO has room
// RREQ  | read data phase, step 1; push the read entry
// RWAIT | read data phase, step 2; wait for the response entry and pop it
// ERR1  | first ERROR cycle (hreadyout low)
// ERR2  | second ERROR cycle (hreadyout high); no address phase accepted
module ahb_req_packer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             wclk,
    input  logic                             reset_n,
    input  logic                             hsel,
    input  logic [ADDR_WIDTH-1:0]            haddr,
    input  logic [1:0]                       htrans,
    input  logic                             hwrite,
    input  logic [2:0]                       hsize,
    input  logic [2:0]                       hburst,
    input  logic [DATA_WIDTH-1:0]            hwdata,
    input  logic                             hready_in,
    output logic                             hreadyout,
    output logic                             hresp,
    output logic [DATA_WIDTH-1:0]            hrdata,
    output logic                             req_wen,
    output logic [ADDR_WIDTH+DATA_WIDTH+8:0] req_wdata,
    input  logic                             req_full,
    input  logic [DATA_WIDTH:0]              rsp_rdata,
    input  logic                             rsp_empty,
    output logic                             rsp_ren
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WDATA = 3'd1;
    localparam logic [2:0] S_RREQ  = 3'd2;
    localparam logic [2:0] S_RWAIT = 3'd3;
    localparam logic [2:0] S_ERR1  = 3'd4;
    localparam logic [2:0] S_ERR2  = 3'd5;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [2:0]            w_addr_next;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [2:0]            r_size;
    logic [2:0]            r_burst;
    logic [1:0]            r_trans;
    logic [DATA_WIDTH-1:0] r_hrdata;

    logic                  w_addr_valid;
    logic                  w_phase_done;
    logic                  w_accept;
    logic                  w_rsp_err;
    logic                  w_rsp_take;
    logic [DATA_WIDTH-1:0] w_wdata_field;

    assign w_addr_valid = hsel & hready_in & htrans[1];
    assign w_rsp_err    = rsp_rdata[DATA_WIDTH];
    assign w_rsp_take   = (r_state == S_RWAIT) & ~rsp_empty;

    // A new address phase may only be taken in a cycle where this slave
    // completes its current data phase with OKAY; ERROR cycles never accept.
    always_comb begin
        w_phase_done = 1'b0;
        case (r_state)
            S_IDLE:  w_phase_done = 1'b1;
            S_WDATA: w_phase_done = ~req_full;
            S_RWAIT: w_phase_done = ~rsp_empty & ~w_rsp_err;
            default: w_phase_done = 1'b0;
        endcase
    end

    assign w_accept = w_addr_valid & w_phase_done;

    // Where the overlapping address phase sends us once the data phase ends.
    always_comb begin
        w_addr_next = S_IDLE;
        if (w_accept) begin
            if (hsize > 3'd2)
                w_addr_next = S_ERR1;
            else if (hwrite)
                w_addr_next = S_WDATA;
            else
                w_addr_next = S_RREQ;
        end
    end

    // Next-state selection.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = w_addr_next;
            S_WDATA: if (!req_full) w_next_state = w_addr_next;
            S_RREQ:  if (!req_full) w_next_state = S_RWAIT;
            S_RWAIT: begin
                if (!rsp_empty)
                    w_next_state = w_rsp_err ? S_ERR2 : w_addr_next;
            end
            S_ERR1:  w_next_state = S_ERR2;
            S_ERR2:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register; reset aborts whatever transfer is in flight.
    always_ff @(posedge wclk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // Capture address-phase control when the transfer is accepted.
    always_ff @(posedge wclk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= 3'd0;
            r_burst <= 3'd0;
            r_trans <= 2'b00;
        end else if (w_accept) begin
            r_addr  <= haddr;
            r_write <= hwrite;
            r_size  <= hsize;
            r_burst <= hburst;
            r_trans <= htrans;
        end
    end

    // Hold the last returned read data between read completions.
    always_ff @(posedge wclk or negedge reset_n) begin
        if (!reset_n)
            r_hrdata <= '0;
        else if (w_rsp_take)
            r_hrdata <= rsp_rdata[DATA_WIDTH-1:0];
    end

    // Bus handshake and FIFO strobes, decoded from state and FIFO flags.
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        req_wen   = 1'b0;
        rsp_ren   = 1'b0;
        case (r_state)
            S_WDATA: begin
                hreadyout = ~req_full;
                req_wen   = ~req_full;
            end
            S_RREQ: begin
                hreadyout = 1'b0;
                req_wen   = ~req_full;
            end
            S_RWAIT: begin
                rsp_ren = ~rsp_empty;
                if (rsp_empty) begin
                    hreadyout = 1'b0;
                end else if (w_rsp_err) begin
                    hreadyout = 1'b0;
                    hresp     = 1'b1;
                end
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            S_ERR2: begin
                hreadyout = 1'b1;
                hresp     = 1'b1;
            end
            default: begin
                hreadyout = 1'b1;
                hresp     = 1'b0;
            end
        endcase
    end

    // Read entries carry zero in the data field; write data comes straight
    // from the bus during the data phase.
    assign w_wdata_field = (r_state == S_WDATA) ? hwdata : '0;
    assign req_wdata     = {r_write, r_addr, w_wdata_field, r_size, r_burst, r_trans};

    // Response data is forwarded in the completing cycle, then held.
    assign hrdata = w_rsp_take ? rsp_rdata[DATA_WIDTH-1:0] : r_hrdata;

endmodule

// File: tb/tb_ahb_req_packer.sv
// Testbench for ahb_req_packer: directed AHB sequences plus a randomized
// mixed read/write run, checked against an entry-queue reference model.
module tb_ahb_req_packer;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int EW    = AW + DW + 9;
    localparam int LIMIT = 200;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic          wclk = 1'b0;
    logic          reset_n = 1'b1;
    logic          hsel = 1'b0;
    logic [AW-1:0] haddr = '0;
    logic [1:0]    htrans = T_IDLE;
    logic          hwrite = 1'b0;
    logic [2:0]    hsize = 3'd0;
    logic [2:0]    hburst = 3'd0;
    logic [DW-1:0] hwdata = '0;
    wire           hready_in;
    logic          hreadyout;
    logic          hresp;
    logic [DW-1:0] hrdata;
    logic          req_wen;
    logic [EW-1:0] req_wdata;
    logic          req_full = 1'b0;
    logic [DW:0]   rsp_rdata = '0;
    logic          rsp_empty = 1'b1;
    logic          rsp_ren;

    // Single slave on the bus: HREADY is this slave's own HREADYOUT.
    assign hready_in = hreadyout;

    ahb_req_packer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .wclk      (wclk),
        .reset_n   (reset_n),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .hwdata    (hwdata),
        .hready_in (hready_in),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .req_wen   (req_wen),
        .req_wdata (req_wdata),
        .req_full  (req_full),
        .rsp_rdata (rsp_rdata),
        .rsp_empty (rsp_empty),
        .rsp_ren   (rsp_ren)
    );

    always #5 wclk = ~wclk;

    int total = 0;
    int bad   = 0;

    // Reference model: the ordered list of entries the FIFO must receive.
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] act_q[$];
    int            n_ren      = 0;
    int            viol_full  = 0;
    int            viol_ren   = 0;

    // Responder controls (written only by the main sequence).
    int            rsp_delay = 2;
    bit            force_en  = 1'b0;
    logic [DW:0]   force_val = '0;

    function automatic logic [EW-1:0] ent(input logic w, input logic [AW-1:0] a,
                                          input logic [DW-1:0] d, input logic [2:0] s,
                                          input logic [2:0] b, input logic [1:0] t);
        logic [DW-1:0] dd;
        dd = w ? d : '0;
        return {w, a, dd, s, b, t};
    endfunction

    function automatic logic [DW-1:0] rd_func(input logic [AW-1:0] a);
        return a ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Records every FIFO push and pop as the DUT presents them.
    always @(negedge wclk) begin
        if (req_wen) begin
            act_q.push_back(req_wdata);
            if (req_full) viol_full++;
        end
        if (rsp_ren) begin
            n_ren++;
            if (rsp_empty) viol_ren++;
        end
    end

    // Response FIFO model: answers each pushed read after rsp_delay cycles.
    always begin : responder
        logic          saw_rd;
        logic          saw_ren;
        logic [AW-1:0] rd_a;
        logic [AW-1:0] aq[$];
        int            cd;
        cd = -1;
        forever begin
            @(negedge wclk);
            saw_rd  = reset_n && req_wen && !req_wdata[EW-1];
            rd_a    = req_wdata[EW-2 -: AW];
            saw_ren = rsp_ren;
            @(posedge wclk);
            #1;
            if (!reset_n) begin
                rsp_empty = 1'b1;
                aq.delete();
                cd = -1;
            end else begin
                if (saw_ren) rsp_empty = 1'b1;
                if (saw_rd) aq.push_back(rd_a);
                if (rsp_empty && aq.size() > 0) begin
                    if (cd < 0) cd = rsp_delay;
                    if (cd == 0) begin
                        rsp_rdata = force_en ? force_val : {1'b0, rd_func(aq[0])};
                        rsp_empty = 1'b0;
                        void'(aq.pop_front());
                        cd = -1;
                    end else begin
                        cd--;
                    end
                end
            end
        end
    end

    task automatic drv(input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [AW-1:0] a, input logic [2:0] sz,
                       input logic [2:0] bu, input logic [DW-1:0] wd);
        hsel = sel; htrans = tr; hwrite = wr; haddr = a;
        hsize = sz; hburst = bu; hwdata = wd;
    endtask

    // Runs bus cycles until hreadyout completes one; returns wait count and
    // the read data / response seen in the completing cycle.
    task automatic cycle(output int waits, output logic [DW-1:0] rd, output logic rs);
        bit done;
        done = 1'b0; waits = 0; rd = '0; rs = 1'b0;
        while (!done) begin
            @(negedge wclk);
            if (hreadyout === 1'b1) begin
                done = 1'b1; rd = hrdata; rs = hresp;
            end else if (waits >= LIMIT) begin
                total++; bad++;
                $error("FAIL ready_timeout waits=%0d limit=%0d", waits, LIMIT);
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge wclk);
            #1;
        end
    endtask

    task automatic compare_q(input string tag);
        chk({tag, "_count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            chk({tag, "_entry"}, act_q[i], exp_q[i]);
        act_q.delete();
        exp_q.delete();
    endtask

    initial begin : main
        int            w;
        logic [DW-1:0] rd;
        logic          rs;
        int            ren0;
        int            k;
        logic [DW-1:0] bd[20];
        logic [AW-1:0] ba[20];
        logic          pv_rd, pv_wr;
        logic [AW-1:0] pv_addr;
        logic [DW-1:0] pv_data;

        // Reset values.
        #2 reset_n = 1'b0;
        #2;
        chk("rst_hreadyout", hreadyout, 1'b1);
        chk("rst_hresp", hresp, 1'b0);
        chk("rst_hrdata", hrdata, '0);
        chk("rst_req_wen", req_wen, 1'b0);
        chk("rst_rsp_ren", rsp_ren, 1'b0);
        repeat (2) @(posedge wclk);
        #3 reset_n = 1'b1;
        @(posedge wclk);
        #1;

        // Single posted write.
        drv(1, T_NONSEQ, 1, 32'h4000_0010, 3'd2, 3'd0, '0);
        exp_q.push_back(ent(1, 32'h4000_0010, 32'hDEAD_BEEF, 3'd2, 3'd0, T_NONSEQ));
        cycle(w, rd, rs);
        chk("wr_addr_wait", w, 0);
        drv(0, T_IDLE, 0, '0, 3'd0, 3'd0, 32'hDEAD_BEEF);
        cycle(w, rd, rs);
        chk("wr_data_wait", w, 0);
        chk("wr_resp", rs, 1'b0);
        compare_q("single_wr");

        // 20 back-to-back writes, FIFO full after the 16th push.
        for (int i = 0; i < 20; i++) begin
            ba[i] = 32'h4000_1000 + 32'(i * 4);
            bd[i] = $urandom;
        end
        for (int c = 0; c <= 20; c++) begin
            if (c < 20) begin
                drv(1, (c == 0) ? T_NONSEQ : T_SEQ, 1, ba[c], 3'd2, 3'd1, (c > 0) ? bd[c-1] : '0);
                exp_q.push_back(ent(1, ba[c], bd[c], 3'd2, 3'd1, (c == 0) ? T_NONSEQ : T_SEQ));
            end else begin
                drv(0, T_IDLE, 0, '0, 3'd0, 3'd0, bd[19]);
            end
            if (c == 17) begin
                chk("pushes_before_full", act_q.size(), 16);
                req_full = 1'b1;
                repeat (4) begin
                    @(negedge wclk);
                    chk("full_stall_ready", hreadyout, 1'b0);
                    chk("full_no_wen", req_wen, 1'b0);
                    @(posedge wclk);
                    #1;
                end
                req_full = 1'b0;
            end
            cycle(w, rd, rs);
            if (c != 17) chk("burst_zero_wait", w, 0);
        end
        compare_q("burst");

        // Read with a delayed OKAY response.
        force_en = 1'b1; force_val = 33'h0_1234_5678; rsp_delay = 5;
        ren0 = n_ren;
        drv(1, T_NONSEQ, 0, 32'h4000_0004, 3'd2, 3'd0, '0);
        exp_q.push_back(ent(0, 32'h4000_0004, 32'hFFFF_FFFF, 3'd2, 3'd0, T_NONSEQ));
        cycle(w, rd, rs);
        drv(0, T_IDLE, 0, '0, 3'd0, 3'd0, '0);
        cycle(w, rd, rs);
        chk("rd_min_waits", w >= 2, 1'b1);
        chk("rd_hrdata", rd, 32'h1234_5678);
        chk("rd_hresp", rs, 1'b0);
        cycle(w, rd, rs);
        chk("rd_ren_pulses", n_ren - ren0, 1);
        chk("rd_hrdata_held", hrdata, 32'h1234_5678);
        compare_q("read");

        // Read answered with a slave error.
        force_val = 33'h1_0000_0000; rsp_delay = 3;
        ren0 = n_ren;
        drv(1, T_NONSEQ, 0, 32'h4000_0020, 3'd2, 3'd0, '0);
        exp_q.push_back(ent(0, 32'h4000_0020, '0, 3'd2, 3'd0, T_NONSEQ));
        cycle(w, rd, rs);
        drv(0, T_IDLE, 0, '0, 3'd0, 3'd0, '0);
        k = 0;
        @(negedge wclk);
        while (hresp !== 1'b1 && k < 50) begin
            @(posedge wclk);
            @(negedge wclk);
            k++;
        end
        chk("rderr_c1_ready", hreadyout, 1'b0);
        chk("rderr_c1_resp", hresp, 1'b1);
        chk("rderr_c1_ren", rsp_ren, 1'b1);
        @(negedge wclk);
        chk("rderr_c2_ready", hreadyout, 1'b1);
        chk("rderr_c2_resp", hresp, 1'b1);
        @(negedge wclk);
        chk("rderr_idle_ready", hreadyout, 1'b1);
        chk("rderr_idle_resp", hresp, 1'b0);
        chk("rderr_ren_pulses", n_ren - ren0, 1);
        @(posedge wclk);
        #1;
        compare_q("read_err");
        force_en = 1'b0;

        // Oversized write: ERROR, no entry.
        drv(1, T_NONSEQ, 1, 32'h4000_0030, 3'd3, 3'd0, '0);
        cycle(w, rd, rs);
        drv(0, T_IDLE, 0, '0, 3'd0, 3'd0, 32'h1111_2222);
        @(negedge wclk);
        chk("size3_c1_ready", hreadyout, 1'b0);
        chk("size3_c1_resp", hresp, 1'b1);
        chk("size3_c1_wen", req_wen, 1'b0);
        @(negedge wclk);
        chk("size3_c2_ready", hreadyout, 1'b1);
        chk("size3_c2_resp", hresp, 1'b1);
        @(negedge wclk);
        chk("size3_idle_resp", hresp, 1'b0);
        @(posedge wclk);
        #1;
        compare_q("size3");

        // Randomized mixed traffic.
        pv_rd = 1'b0; pv_wr = 1'b0; pv_addr = '0; pv_data = '0;
        for (int i = 0; i <= 40; i++) begin
            logic          sel, wr;
            logic [1:0]    tr;
            logic [2:0]    sz, bu;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            int            kind;
            bit            acc;
            kind = $urandom_range(0, 5);
            sel  = (i < 40) && ($urandom_range(0, 7) != 0);
            tr   = (i == 40) ? T_IDLE : (kind == 5) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            wr   = (kind < 3);
            sz   = 3'($urandom_range(0, 2));
            bu   = 3'($urandom_range(0, 7));
            a    = $urandom;
            d    = $urandom;
            drv(sel, tr, wr, a, sz, bu, pv_wr ? pv_data : DW'($urandom));
            rsp_delay = $urandom_range(0, 4);
            acc = sel && tr[1];
            if (acc) exp_q.push_back(ent(wr, a, d, sz, bu, tr));
            cycle(w, rd, rs);
            if (pv_rd) begin
                chk("rand_rd_data", rd, rd_func(pv_addr));
                chk("rand_rd_resp", rs, 1'b0);
            end
            if (pv_wr) chk("rand_wr_wait", w, 0);
            pv_rd = acc && !wr; pv_wr = acc && wr; pv_addr = a; pv_data = d;
        end
        compare_q("random");

        // Reset while waiting for a read response.
        rsp_delay = 1000;
        drv(1, T_NONSEQ, 0, 32'h4000_0040, 3'd2, 3'd0, '0);
        exp_q.push_back(ent(0, 32'h4000_0040, '0, 3'd2, 3'd0, T_NONSEQ));
        cycle(w, rd, rs);
        drv(0, T_IDLE, 0, '0, 3'd0, 3'd0, '0);
        @(negedge wclk);
        @(negedge wclk);
        chk("rwait_stalled", hreadyout, 1'b0);
        @(posedge wclk);
        #3 reset_n = 1'b0;
        #1;
        chk("abort_ready", hreadyout, 1'b1);
        chk("abort_resp", hresp, 1'b0);
        chk("abort_ren", rsp_ren, 1'b0);
        chk("abort_hrdata", hrdata, '0);
        @(posedge wclk);
        #3 reset_n = 1'b1;
        @(posedge wclk);
        #1;
        rsp_delay = 2;
        drv(1, T_NONSEQ, 1, 32'h4000_0050, 3'd1, 3'd0, '0);
        exp_q.push_back(ent(1, 32'h4000_0050, 32'hCAFE_F00D, 3'd1, 3'd0, T_NONSEQ));
        cycle(w, rd, rs);
        drv(0, T_IDLE, 0, '0, 3'd0, 3'd0, 32'hCAFE_F00D);
        cycle(w, rd, rs);
        chk("post_rst_wr_wait", w, 0);
        cycle(w, rd, rs);
        compare_q("post_reset");

        chk("wen_while_full", viol_full, 0);
        chk("ren_while_empty", viol_ren, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_req_packer.md
# ahb_req_packer

AHB-Lite slave front end of the AHB-APB bridge, clocked by wclk (HCLK). Captures AHB address/data phases and packs each transfer into one entry written into the request async FIFO. Reads stall until a response appears in the response FIFO. Writes are posted with zero wait states unless the request FIFO is full.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HWDATA/HRDATA width; request entry width = ADDR_WIDTH+DATA_WIDTH+9 (73 at defaults)
- wclk  in  1  AHB clock (HCLK); all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- hsel  in  1  slave select
- haddr  in  ADDR_WIDTH  address
- htrans  in  2  transfer type
- hwrite  in  1  1 = write
- hsize  in  3  transfer size
- hburst  in  3  burst type; forwarded only
- hwdata  in  DATA_WIDTH  write data; valid in data phase
- hready_in  in  1  bus HREADY
- hreadyout  out  1  slave ready
- hresp  out  1  0 = OKAY, 1 = ERROR
- hrdata  out  DATA_WIDTH  read data
- req_wen  out  1  request FIFO write enable
- req_wdata  out  ADDR_WIDTH+DATA_WIDTH+9  packed entry
- req_full  in  1  request FIFO full
- rsp_rdata  in  DATA_WIDTH+1  response entry: bit [DATA_WIDTH] = slave error, lower bits = read data
- rsp_empty  in  1  response FIFO empty
- rsp_ren  out  1  response FIFO read enable

## Operation
- Entry packing, MSB first: {write, addr, wdata, hsize, hburst, htrans}; at defaults [72] write, [71:40] addr, [39:8] wdata, [7:5] hsize, [4:2] hburst, [1:0] htrans. Read entries carry wdata = 0.
- Address phase is accepted when hsel & hready_in & htrans[1] (NONSEQ/SEQ). On acceptance, register addr, write, hsize, hburst, htrans.
- IDLE/BUSY transfers, or hsel = 0: no entry, OKAY, zero wait.
- FSM states: IDLE, WDATA, RREQ, RWAIT, ERR1, ERR2.
- IDLE: hreadyout = 1, hresp = 0.
  - Accepted write -> WDATA.
  - Accepted read -> RREQ.
  - Accepted transfer with hsize > 2 (wider than 32 bits) -> ERR1, no entry written.
- WDATA: hreadyout = !req_full.
  - When !req_full: req_wen = 1 with captured ctrl + current hwdata, then go to next state per the overlapping address phase (IDLE/WDATA/RREQ/ERR1).
  - When full: stall, no push.
- RREQ: hreadyout = 0. When !req_full: push read entry and go to RWAIT.
- RWAIT: hreadyout = 0 while rsp_empty.
  - When !rsp_empty: rsp_ren = 1 for exactly one cycle and hrdata = rsp_rdata[DATA_WIDTH-1:0].
  - Error bit = 0: hreadyout = 1, hresp = 0, go to the next state per the overlapping address phase.
  - Error bit = 1: hreadyout = 0, hresp = 1, go to ERR2. This cycle serves as ERR1.
- ERR1: hreadyout = 0, hresp = 1 -> ERR2.
- ERR2: hreadyout = 1, hresp = 1 -> IDLE. The address phase is not accepted in ERR2.
- hrdata is held at its last value outside RWAIT completion. Reset value is 0.

## Timing
- Reset values: hreadyout = 1, hresp = 0, hrdata = 0, req_wen = 0, rsp_ren = 0, FSM = IDLE.
- Async assert aborts any transfer mid-operation: no push, no pop, captured control discarded.
- Write latency: entry written on the data-phase edge. Back-to-back writes give one push per cycle with zero wait states.
- Full boundary: req_full sampled combinationally. req_wen is never asserted while req_full = 1.
- Read latency: minimum 2 wait states (RREQ push, then RWAIT), plus the response FIFO round trip.
- Simultaneous events: a write data phase overlapping a read address phase pushes the write first; RREQ pushes the read on the next edge.
- rsp_ren is asserted only when !rsp_empty and only in RWAIT.
- The 2-cycle ERROR response follows AHB-Lite: hresp = 1 in both cycles, hreadyout low then high.

## Test plan
- Single write, haddr = 0x40000010, hwdata = 0xDEADBEEF, hsize = 2 -> one req_wen pulse, req_wdata = {1, 0x40000010, 0xDEADBEEF, 3'd2, hburst, 2'b10}, zero wait states.
- 20 back-to-back writes with req_full asserted after the 16th -> 16 pushes; hreadyout low until full drops; remaining 4 pushed in order; no push while full.
- Read of 0x40000004, response 0x0_12345678 returned 5 cycles later -> read entry with wdata = 0, hrdata = 0x12345678, rsp_ren single pulse, hresp = 0.
- Read with response 0x1_00000000 -> rsp_ren pulse, hresp = 1 for 2 cycles with hreadyout 0 then 1, then IDLE.
- Accepted write with hsize = 3 -> no req_wen, 2-cycle ERROR response.
- reset_n dropped in RWAIT -> hreadyout = 1, hresp = 0, rsp_ren = 0 immediately; next accepted write after release pushes normally.
